multicycle_controller: RTL and testbench

Control FSM for the multicycle RV32I core: sequences a shared ALU, a unified instruction/data memory and the register file over several clocks per instruction. Instead of one cycle of combinational decode, it decodes `op`/`funct3`/`funct7b5` once per instruction and walks a Moore state machine. The machine drives write enables, mux selects and a 4-bit `ALUControl` to the multicycle datapath. A retired-instruction counter is included for verification and performance measurement.

---
 rtl/multicycle_controller.sv | 209 ++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// ============================================================================
// Module   : multicycle_controller
// Purpose  : Moore control FSM sequencing the multicycle RV32I datapath,
//            with a retired-instruction counter.
// Revision : 1.0
// ============================================================================
`default_nettype none

module multicycle_controller (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  op,
  input  logic [2:0]  funct3,
  input  logic        funct7b5,
  input  logic        Zero,
  output logic        PCWrite,
  output logic        AdrSrc,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic [1:0]  ResultSrc,
  output logic [1:0]  ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic        RegWrite,
  output logic [1:0]  ImmSrc,
  output logic [3:0]  ALUControl,
  output logic [3:0]  state_o,
  output logic [31:0] instret_o
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    ALUWB    = 4'd7,
    EXECUTEI = 4'd8,
    JAL      = 4'd9,
    BRANCH   = 4'd10
  } state_t;

  localparam logic [6:0] C_OP_LW     = 7'b0000011;
  localparam logic [6:0] C_OP_SW     = 7'b0100011;
  localparam logic [6:0] C_OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] C_OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] C_OP_JAL    = 7'b1101111;
  localparam logic [6:0] C_OP_BRANCH = 7'b1100011;

  localparam logic [1:0] C_ALUOP_ADD   = 2'b00;
  localparam logic [1:0] C_ALUOP_SUB   = 2'b01;
  localparam logic [1:0] C_ALUOP_FUNCT = 2'b10;

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_instret;
  logic        w_retire;

  logic        w_pc_update;
  logic        w_branch;
  logic        w_adr_src;
  logic        w_mem_write;
  logic        w_ir_write;
  logic        w_reg_write;
  logic [1:0]  w_result_src;
  logic [1:0]  w_alu_src_a;
  logic [1:0]  w_alu_src_b;
  logic [1:0]  w_alu_op;
  logic [3:0]  w_alu_funct;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= FETCH;
      r_instret <= '0;
    end else begin
      r_state <= w_next;
      if (w_retire) r_instret <= r_instret + 32'd1;
    end
  end

  // Terminal states of each legal instruction retire on the edge leaving them.
  assign w_retire = (r_state == MEMWB) || (r_state == MEMWRITE) ||
                    (r_state == ALUWB) || (r_state == BRANCH);

  always_comb begin
    w_next       = FETCH;
    w_pc_update  = 1'b0;
    w_branch     = 1'b0;
    w_adr_src    = 1'b0;
    w_mem_write  = 1'b0;
    w_ir_write   = 1'b0;
    w_reg_write  = 1'b0;
    w_result_src = 2'b00;
    w_alu_src_a  = 2'b00;
    w_alu_src_b  = 2'b00;
    w_alu_op     = C_ALUOP_ADD;
    case (r_state)
      FETCH: begin
        w_next       = DECODE;
        w_ir_write   = 1'b1;
        w_alu_src_b  = 2'b10;
        w_result_src = 2'b10;
        w_pc_update  = 1'b1;
      end
      DECODE: begin
        w_alu_src_a = 2'b01;
        w_alu_src_b = 2'b01;
        case (op)
          C_OP_LW, C_OP_SW: w_next = MEMADR;
          C_OP_RTYPE:       w_next = EXECUTER;
          C_OP_ITYPE:       w_next = EXECUTEI;
          C_OP_JAL:         w_next = JAL;
          C_OP_BRANCH:      w_next = BRANCH;
          default:          w_next = FETCH;
        endcase
      end
      MEMADR: begin
        w_next      = (op == C_OP_LW) ? MEMREAD : MEMWRITE;
        w_alu_src_a = 2'b10;
        w_alu_src_b = 2'b01;
      end
      MEMREAD: begin
        w_next    = MEMWB;
        w_adr_src = 1'b1;
      end
      MEMWB: begin
        w_result_src = 2'b01;
        w_reg_write  = 1'b1;
      end
      MEMWRITE: begin
        w_adr_src   = 1'b1;
        w_mem_write = 1'b1;
      end
      EXECUTER: begin
        w_next      = ALUWB;
        w_alu_src_a = 2'b10;
        w_alu_op    = C_ALUOP_FUNCT;
      end
      EXECUTEI: begin
        w_next      = ALUWB;
        w_alu_src_a = 2'b10;
        w_alu_src_b = 2'b01;
        w_alu_op    = C_ALUOP_FUNCT;
      end
      ALUWB: begin
        w_reg_write = 1'b1;
      end
      JAL: begin
        w_next      = ALUWB;
        w_alu_src_a = 2'b01;
        w_alu_src_b = 2'b10;
        w_pc_update = 1'b1;
      end
      BRANCH: begin
        w_alu_src_a = 2'b10;
        w_alu_op    = C_ALUOP_SUB;
        w_branch    = 1'b1;
      end
      default: w_next = FETCH;
    endcase
  end

  always_comb begin
    w_alu_funct = 4'b0000;
    case (funct3)
      3'b000: w_alu_funct = (op[5] && funct7b5) ? 4'b0001 : 4'b0000;
      3'b001: w_alu_funct = 4'b0111;
      3'b010: w_alu_funct = 4'b0101;
      3'b011: w_alu_funct = 4'b0110;
      3'b100: w_alu_funct = 4'b0100;
      3'b101: w_alu_funct = funct7b5 ? 4'b1001 : 4'b1000;
      3'b110: w_alu_funct = 4'b0011;
      default: w_alu_funct = 4'b0010;
    endcase
  end

  always_comb begin
    case (w_alu_op)
      C_ALUOP_SUB:   ALUControl = 4'b0001;
      C_ALUOP_FUNCT: ALUControl = w_alu_funct;
      default:       ALUControl = 4'b0000;
    endcase
  end

  always_comb begin
    case (op)
      C_OP_SW:     ImmSrc = 2'b01;
      C_OP_BRANCH: ImmSrc = 2'b10;
      C_OP_JAL:    ImmSrc = 2'b11;
      default:     ImmSrc = 2'b00;
    endcase
  end

  // Write enables are held low for the whole reset interval, not just at the edge.
  assign PCWrite   = ~reset & (w_pc_update | (w_branch & (Zero ^ funct3[0])));
  assign IRWrite   = ~reset & w_ir_write;
  assign MemWrite  = ~reset & w_mem_write;
  assign RegWrite  = ~reset & w_reg_write;
  assign AdrSrc    = w_adr_src;
  assign ResultSrc = w_result_src;
  assign ALUSrcA   = w_alu_src_a;
  assign ALUSrcB   = w_alu_src_b;
  assign state_o   = r_state;
  assign instret_o = r_instret;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_controller.sv
// ============================================================================
// Module   : tb_multicycle_controller
// Purpose  : Directed scoreboard bench for the multicycle control FSM.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_multicycle_controller;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [6:0]  op = 7'd0;
  logic [2:0]  funct3 = 3'd0;
  logic        funct7b5 = 1'b0;
  logic        Zero = 1'b0;
  logic        PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
  logic [1:0]  ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [3:0]  ALUControl, state_o;
  logic [31:0] instret_o;

  multicycle_controller dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .Zero(Zero), .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .RegWrite(RegWrite), .ImmSrc(ImmSrc),
    .ALUControl(ALUControl), .state_o(state_o), .instret_o(instret_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] st;
    logic       pcw;
    logic       adr;
    logic       memw;
    logic       irw;
    logic [1:0] res;
    logic [1:0] srca;
    logic [1:0] srcb;
    logic       regw;
    logic [1:0] imm;
    logic [3:0] aluc;
  } outs_t;

  typedef struct packed {
    outs_t       o;
    logic [31:0] cnt;
  } exp_t;

  exp_t        sb[$];
  int          n_total = 0;
  int          n_pass = 0;
  logic [31:0] model_cnt = 32'd0;

  function automatic outs_t observed();
    outs_t v;
    v = {state_o, PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA,
         ALUSrcB, RegWrite, ImmSrc, ALUControl};
    return v;
  endfunction

  // Reference table written straight from the state/output list.
  function automatic outs_t model(input logic [3:0] st, input logic rst);
    outs_t      m;
    logic [3:0] fn;
    m    = '0;
    m.st = st;
    case (op)
      7'b0100011: m.imm = 2'b01;
      7'b1100011: m.imm = 2'b10;
      7'b1101111: m.imm = 2'b11;
      default:    m.imm = 2'b00;
    endcase
    case (funct3)
      3'd0:    fn = (op[5] && funct7b5) ? 4'd1 : 4'd0;
      3'd1:    fn = 4'd7;
      3'd2:    fn = 4'd5;
      3'd3:    fn = 4'd6;
      3'd4:    fn = 4'd4;
      3'd5:    fn = funct7b5 ? 4'd9 : 4'd8;
      3'd6:    fn = 4'd3;
      default: fn = 4'd2;
    endcase
    case (st)
      4'd0:  begin m.irw = 1'b1; m.pcw = 1'b1; m.srcb = 2'd2; m.res = 2'd2; end
      4'd1:  begin m.srca = 2'd1; m.srcb = 2'd1; end
      4'd2:  begin m.srca = 2'd2; m.srcb = 2'd1; end
      4'd3:  m.adr = 1'b1;
      4'd4:  begin m.res = 2'd1; m.regw = 1'b1; end
      4'd5:  begin m.adr = 1'b1; m.memw = 1'b1; end
      4'd6:  begin m.srca = 2'd2; m.aluc = fn; end
      4'd7:  m.regw = 1'b1;
      4'd8:  begin m.srca = 2'd2; m.srcb = 2'd1; m.aluc = fn; end
      4'd9:  begin m.srca = 2'd1; m.srcb = 2'd2; m.pcw = 1'b1; end
      4'd10: begin m.srca = 2'd2; m.aluc = 4'd1; m.pcw = Zero ^ funct3[0]; end
      default: ;
    endcase
    if (rst) begin
      m.pcw = 1'b0; m.irw = 1'b0; m.memw = 1'b0; m.regw = 1'b0;
    end
    return m;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Entered at a falling edge with the FSM in FETCH; leaves at the falling
  // edge where the next FETCH is showing.
  task automatic run(input string tag, input logic [6:0] o, input logic [2:0] f3,
                     input logic f7, input logic z);
    logic [3:0] path[$];
    exp_t       e;
    bit         legal;
    op = o; funct3 = f3; funct7b5 = f7; Zero = z;
    legal = 1'b1;
    path.push_back(4'd0);
    path.push_back(4'd1);
    case (o)
      7'b0000011: begin path.push_back(4'd2); path.push_back(4'd3); path.push_back(4'd4); end
      7'b0100011: begin path.push_back(4'd2); path.push_back(4'd5); end
      7'b0110011: begin path.push_back(4'd6); path.push_back(4'd7); end
      7'b0010011: begin path.push_back(4'd8); path.push_back(4'd7); end
      7'b1101111: begin path.push_back(4'd9); path.push_back(4'd7); end
      7'b1100011: path.push_back(4'd10);
      default:    legal = 1'b0;
    endcase
    foreach (path[i]) begin
      e.o   = model(path[i], 1'b0);
      e.cnt = model_cnt;
      sb.push_back(e);
    end
    if (legal) model_cnt = model_cnt + 32'd1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      #1;
      check($sformatf("%s/s%0d outs", tag, e.o.st), 32'(observed()), 32'(e.o));
      check($sformatf("%s/s%0d instret", tag, e.o.st), instret_o, e.cnt);
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    #2 reset = 1'b1;
    #1;
    check("reset outs", 32'(observed()), 32'(model(4'd0, 1'b1)));
    check("reset instret", instret_o, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    run("lw", 7'b0000011, 3'b010, 1'b0, 1'b0);

    // Abort a load in MEMREAD with an asynchronous reset.
    op = 7'b0000011; funct3 = 3'b010; funct7b5 = 1'b0;
    repeat (3) @(negedge clk);
    #1 check("pre-abort state", 32'(state_o), 32'd3);
    #2 reset = 1'b1;
    #1;
    check("abort outs", 32'(observed()), 32'(model(4'd0, 1'b1)));
    check("abort instret", instret_o, 32'd0);
    @(posedge clk);
    #1 check("held reset outs", 32'(observed()), 32'(model(4'd0, 1'b1)));
    @(negedge clk);
    reset = 1'b0;
    model_cnt = 32'd0;

    run("sw",       7'b0100011, 3'b010, 1'b0, 1'b0);
    run("sub",      7'b0110011, 3'b000, 1'b1, 1'b0);
    run("addi",     7'b0010011, 3'b000, 1'b1, 1'b0);
    run("sra",      7'b0110011, 3'b101, 1'b1, 1'b0);
    run("srai",     7'b0010011, 3'b101, 1'b1, 1'b0);
    run("and",      7'b0110011, 3'b111, 1'b0, 1'b0);
    run("slti",     7'b0010011, 3'b010, 1'b0, 1'b0);
    run("beq z1",   7'b1100011, 3'b000, 1'b0, 1'b1);
    run("beq z0",   7'b1100011, 3'b000, 1'b0, 1'b0);
    run("bne z1",   7'b1100011, 3'b001, 1'b0, 1'b1);
    run("bne z0",   7'b1100011, 3'b001, 1'b0, 1'b0);
    run("jal",      7'b1101111, 3'b000, 1'b0, 1'b0);
    run("illegal",  7'b0000000, 3'b000, 1'b0, 1'b0);

    force dut.r_instret = 32'hFFFF_FFFF;
    #1 release dut.r_instret;
    model_cnt = 32'hFFFF_FFFF;
    run("wrap beq", 7'b1100011, 3'b000, 1'b0, 1'b1);
    #1 check("wrap final", instret_o, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
